// File: rtl/if_fetch_buf.sv
// Instruction-fetch front end: owns the PC, issues pipelined ROM requests,
// buffers in-order responses and hands them to IF/ID with valid/ready plus redirect flush.
module if_fetch_buf #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_gnt_i,
  input  logic              rom_rvalid_i,
  input  logic [INST_W-1:0] rom_data_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int unsigned       PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned       SUM_W   = CNT_W + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_W / 8);
  localparam logic [SUM_W-1:0]  DEPTH_S = SUM_W'(DEPTH);

  logic [INST_W-1:0] q_inst [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [ADDR_W-1:0] ipc    [DEPTH];

  logic [ADDR_W-1:0] pc, pc_n;
  logic [PTR_W-1:0]  rd_ptr, rd_n, wr_ptr, wr_n;
  logic [PTR_W-1:0]  ipc_rd, ipc_rd_n, ipc_wr, ipc_wr_n;
  logic [CNT_W-1:0]  count, count_n, inflight, inflight_n, discard, discard_n;
  logic              req_q, req_n, valid_q, valid_n;
  logic              q_we, ipc_we;
  logic              issue, resp, pop;

  assign issue = req_q & rom_gnt_i;
  // Responses with nothing outstanding are protocol errors and are ignored.
  assign resp  = rom_rvalid_i & (inflight != '0);
  assign pop   = valid_q & inst_ready_i;

  // Next-state decode; redirect overrides queue and PC updates.
  always_comb begin
    pc_n       = pc;
    rd_n       = rd_ptr;
    wr_n       = wr_ptr;
    ipc_rd_n   = ipc_rd;
    ipc_wr_n   = ipc_wr;
    count_n    = count;
    discard_n  = discard;
    inflight_n = inflight + CNT_W'(issue) - CNT_W'(resp);
    q_we       = 1'b0;
    ipc_we     = 1'b0;

    if (issue) begin
      ipc_we   = 1'b1;
      ipc_wr_n = ipc_wr + PTR_W'(1);
      pc_n     = pc + PC_STEP;
    end
    if (resp) begin
      ipc_rd_n = ipc_rd + PTR_W'(1);
    end

    if (redirect_i) begin
      // Every request still outstanding after this edge belongs to the old stream.
      pc_n      = redirect_pc_i;
      rd_n      = wr_ptr;
      count_n   = '0;
      discard_n = inflight_n;
    end else begin
      if (resp) begin
        if (discard != '0) begin
          discard_n = discard - CNT_W'(1);
        end else begin
          q_we = 1'b1;
          wr_n = wr_ptr + PTR_W'(1);
        end
      end
      if (pop) begin
        rd_n = rd_ptr + PTR_W'(1);
      end
      count_n = count + CNT_W'(q_we) - CNT_W'(pop);
    end

    req_n   = (SUM_W'(count_n) + SUM_W'(inflight_n)) < DEPTH_S;
    valid_n = (count_n != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      ipc_rd   <= '0;
      ipc_wr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      pc       <= pc_n;
      rd_ptr   <= rd_n;
      wr_ptr   <= wr_n;
      ipc_rd   <= ipc_rd_n;
      ipc_wr   <= ipc_wr_n;
      count    <= count_n;
      inflight <= inflight_n;
      discard  <= discard_n;
      req_q    <= req_n;
      valid_q  <= valid_n;
      if (q_we) begin
        q_inst[wr_ptr] <= rom_data_i;
        q_pc[wr_ptr]   <= ipc[ipc_rd];
      end
    end
  end

  // Issue-PC tags for outstanding requests; contents only read while tagged.
  always_ff @(posedge clk) begin
    if (ipc_we) begin
      ipc[ipc_wr] <= pc;
    end
  end

  assign rom_req_o    = req_q;
  assign rom_addr_o   = pc;
  assign inst_valid_o = valid_q;
  assign inst_o       = q_inst[rd_ptr];
  assign inst_pc_o    = q_pc[rd_ptr];

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf with a variable-latency in-order ROM model
// and a consumer monitor logging every accepted instruction.
module tb_if_fetch_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int errors = 0;
  int checks = 0;

  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned n_issue = 0;
  logic [31:0] rq_addr[$];
  int unsigned rq_due[$];
  logic [31:0] rx_pc[$];
  logic [31:0] rx_inst[$];
  int unsigned rx_cyc[$];

  if_fetch_buf #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .rom_req_o(req), .rom_addr_o(addr), .rom_gnt_i(gnt),
    .rom_rvalid_i(rvalid), .rom_data_i(rdata),
    .inst_valid_o(valid), .inst_o(inst), .inst_pc_o(inst_pc),
    .inst_ready_i(ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  always #5 clk = ~clk;

  // ROM model: log issues at the edge, answer in order lat edges later with ~addr.
  always @(posedge clk) begin
    if (!rst) begin
      rq_addr.delete();
      rq_due.delete();
      n_issue = 0;
    end else if (req && gnt) begin
      rq_addr.push_back(addr);
      rq_due.push_back(cyc + lat);
      n_issue++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst && rq_addr.size() > 0 && rq_due[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = ~rq_addr[0];
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  end

  always @(negedge rst) begin
    rvalid = 1'b0;
    rq_addr.delete();
    rq_due.delete();
  end

  always @(negedge clk) begin
    #2;
    if (rst && valid && ready) begin
      rx_pc.push_back(inst_pc);
      rx_inst.push_back(inst);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic clear_rx();
    rx_pc.delete();
    rx_inst.delete();
    rx_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 00000000", inst_pc); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL release_req_early: got %b expected 0", req); end
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", req); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 00000000", addr); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_valid_early: got %b expected 0", valid); end
    @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid: got %b expected 1", valid); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL stream_first_pc: got %h expected 00000000", inst_pc); end
    checks++; if (inst !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stream_first_inst: got %h expected ffffffff", inst); end
    clear_rx();
    repeat (16) @(negedge clk);
    checks++;
    if (rx_pc.size() < 12) begin
      errors++; $display("FAIL stream_count: got %0d expected >= 12", rx_pc.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++; if (rx_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, rx_pc[i], 32'(4 * i)); end
        checks++; if (rx_inst[i] !== ~32'(4 * i)) begin errors++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, rx_inst[i], ~32'(4 * i)); end
        checks++; if (rx_cyc[i] !== rx_cyc[0] + 32'(i)) begin errors++; $display("FAIL stream_rate[%0d]: got cycle %0d expected %0d", i, rx_cyc[i], rx_cyc[0] + 32'(i)); end
      end
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0; gnt = 1'b1; lat = 1;
    do_reset();
    repeat (10) @(negedge clk);
    checks++; if (n_issue !== 4) begin errors++; $display("FAIL bp_grants: got %0d expected 4", n_issue); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b expected 0", req); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", valid); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h expected 00000000", inst_pc); end
    clear_rx();
    ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (rx_pc.size() < 8) begin
      errors++; $display("FAIL bp_count: got %0d expected >= 8", rx_pc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (rx_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, rx_pc[i], 32'(4 * i)); end
        checks++; if (rx_inst[i] !== ~32'(4 * i)) begin errors++; $display("FAIL bp_inst[%0d]: got %h expected %h", i, rx_inst[i], ~32'(4 * i)); end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    ready = 1'b1; gnt = 1'b0; lat = 3;
    do_reset();
    repeat (2) @(negedge clk);
    gnt = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (n_issue !== 2) begin errors++; $display("FAIL rdi_issued: got %0d expected 2", n_issue); end
    gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0; gnt = 1'b1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rdi_valid: got %b expected 0", valid); end
    checks++; if (addr !== 32'h100) begin errors++; $display("FAIL rdi_addr: got %h expected 00000100", addr); end
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL rdi_req: got %b expected 1", req); end
    clear_rx();
    repeat (12) @(negedge clk);
    checks++;
    if (rx_pc.size() < 2) begin
      errors++; $display("FAIL rdi_count: got %0d expected >= 2", rx_pc.size());
    end else begin
      checks++; if (rx_pc[0] !== 32'h100) begin errors++; $display("FAIL rdi_pc0: got %h expected 00000100", rx_pc[0]); end
      checks++; if (rx_inst[0] !== ~32'h100) begin errors++; $display("FAIL rdi_inst0: got %h expected fffffeff", rx_inst[0]); end
      checks++; if (rx_pc[1] !== 32'h104) begin errors++; $display("FAIL rdi_pc1: got %h expected 00000104", rx_pc[1]); end
    end
  endtask

  task automatic test_redirect_collision();
    int j;
    ready = 1'b1; gnt = 1'b1; lat = 2;
    do_reset();
    clear_rx();
    repeat (10) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL col_pre_valid: got %b expected 1", valid); end
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL col_pre_req: got %b expected 1", req); end
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL col_valid: got %b expected 0", valid); end
    checks++; if (addr !== 32'h200) begin errors++; $display("FAIL col_addr: got %h expected 00000200", addr); end
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL col_req: got %b expected 1", req); end
    repeat (10) @(negedge clk);
    j = -1;
    for (int i = 0; i < rx_pc.size(); i++) begin
      if (j < 0 && rx_pc[i] === 32'h200) j = i;
    end
    checks++;
    if (j < 1 || rx_pc.size() < j + 3) begin
      errors++; $display("FAIL col_jump: got index %0d of %0d expected >= 1 with 3 after", j, rx_pc.size());
    end else begin
      for (int i = 0; i < j; i++) begin
        checks++; if (rx_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL col_old_pc[%0d]: got %h expected %h", i, rx_pc[i], 32'(4 * i)); end
      end
      for (int i = 0; i < 3; i++) begin
        checks++; if (rx_pc[j + i] !== 32'h200 + 32'(4 * i)) begin errors++; $display("FAIL col_new_pc[%0d]: got %h expected %h", i, rx_pc[j + i], 32'h200 + 32'(4 * i)); end
        checks++; if (rx_inst[j + i] !== ~(32'h200 + 32'(4 * i))) begin errors++; $display("FAIL col_new_inst[%0d]: got %h expected %h", i, rx_inst[j + i], ~(32'h200 + 32'(4 * i))); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    lat = 1;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    clear_rx();
    repeat (10) @(negedge clk);
    checks++;
    if (rx_pc.size() < 4) begin
      errors++; $display("FAIL wrap_count: got %0d expected >= 4", rx_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rx_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, rx_pc[i], exp_pc[i]); end
        checks++; if (rx_inst[i] !== ~exp_pc[i]) begin errors++; $display("FAIL wrap_inst[%0d]: got %h expected %h", i, rx_inst[i], ~exp_pc[i]); end
      end
    end
  endtask

  task automatic test_grant_stall();
    ready = 1'b1; gnt = 1'b0; lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 1", i, req); end
      checks++; if (addr !== 32'h0) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected 00000000", i, addr); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 0", i, valid); end
      if (i == 1) begin
        #1;
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
      end
    end
    gnt = 1'b1;
    clear_rx();
    repeat (8) @(negedge clk);
    checks++;
    if (rx_pc.size() < 4) begin
      errors++; $display("FAIL stall_count: got %0d expected >= 4", rx_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rx_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, rx_pc[i], 32'(4 * i)); end
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b expected 1", valid); end
    #3 rst = 1'b0;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL arst_req: got %b expected 0", req); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL arst_addr: got %h expected 00000000", addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL arst_inst: got %h expected 00000000", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL arst_inst_pc: got %h expected 00000000", inst_pc); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_rx();
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL arst_restart_req: got %b expected 1", req); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL arst_restart_addr: got %h expected 00000000", addr); end
    repeat (8) @(negedge clk);
    checks++;
    if (rx_pc.size() < 3) begin
      errors++; $display("FAIL arst_count: got %0d expected >= 3", rx_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (rx_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL arst_pc[%0d]: got %h expected %h", i, rx_pc[i], 32'(4 * i)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_wrap();
    test_grant_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
